uart_hex_cmd: RTL and testbench
===============================

# uart_hex_cmd

Byte-stream parser sitting directly downstream of the UART receiver. It consumes each received byte (`rx_done` pulse plus `rx_data`) and accumulates ASCII hex digits into a numeric value. On carriage return it commits that value with a one-cycle valid strobe. Every received byte is echoed back as a one-cycle start strobe plus data byte, which drive the UART transmitter's `tx_start`/`din`.

## Interface
- `NDIG`, 4: maximum hex digits per entry; value width `W = 4*NDIG`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rx_done` in 1: one-cycle strobe; `rx_data` valid this cycle.
- `rx_data` in 8: received byte.
- `value` out W: last committed value; held until next commit.
- `value_valid` out 1: one-cycle strobe when `value` updates.
- `err` out 1: one-cycle strobe on an illegal character or digit overflow.
- `digit_cnt` out 3 (`$clog2(NDIG+1)`): digits currently accumulated.
- `echo_start` out 1: one-cycle strobe to transmitter.
- `echo_data` out 8: byte to transmit; held until next echo.

## Operation
- States:
  - IDLE: no digits.
  - ACCUM: 1..NDIG digits.
  - ERR: entry corrupted; discard input until CR or ESC.
- Internal accumulator `acc` (W bits) and counter `cnt`. All actions happen only in cycles with `rx_done=1`.
- Hex digit (`0-9`, `a-f`, `A-F`) → nibble `d`:
  - IDLE: `acc<=d`, `cnt<=1` → ACCUM.
  - ACCUM, `cnt<NDIG`: `acc<={acc[W-5:0],d}`, `cnt+1`.
  - ACCUM, `cnt==NDIG`: `err` pulse → ERR; `acc` unchanged.
  - ERR: ignored.
- CR (0x0D):
  - ACCUM: `value<=acc`, `value_valid` pulse, clear `acc`/`cnt` → IDLE.
  - IDLE: no action.
  - ERR: clear → IDLE, no `value_valid`.
- ESC (0x1B): any state → IDLE, clear `acc`/`cnt`, no strobes.
- BS (0x08):
  - ACCUM: `acc<=acc>>4`, `cnt-1`; if `cnt` reaches 0 → IDLE.
  - IDLE/ERR: ignored.
- LF (0x0A): ignored in all states, no `err`.
- Any other byte: `err` pulse. ACCUM → ERR; IDLE stays IDLE; ERR stays ERR.
- Echo: every received byte, including CR/ESC/BS/illegal bytes, gives `echo_data<=rx_data` and an `echo_start` pulse.
  - The transmitter runs at the same baud, so it always finishes one byte before the next arrives. No echo queueing.
- `value` is never altered except on a commit; ESC and ERR do not clear it.

## Timing
- All outputs registered. `value_valid`, `err`, `echo_start` and the updated `value`/`echo_data`/`digit_cnt` appear exactly 1 cycle after the `rx_done` cycle.
- Strobes are exactly one cycle wide. Back-to-back `rx_done` on consecutive cycles is legal; each byte is processed in order with no loss.
- `value_valid` and `echo_start` assert in the same cycle for a CR commit. `err` and `echo_start` coincide for a rejected byte.
- Reset values:
  - `value=0`, `value_valid=0`, `err=0`, `echo_start=0`, `echo_data=0`, `digit_cnt=0`.
  - State IDLE, `acc=0`.
- Reset has priority over an `rx_done` in the same cycle; that byte is dropped and not echoed.
- Reset mid-entry discards partial digits; `value` returns to 0.

## Structure
- Shared package `uart_pkg`:
  - character constants `CHAR_CR`, `CHAR_LF`, `CHAR_ESC`, `CHAR_BS`;
  - state enum `hex_cmd_state_t` {IDLE, ACCUM, ERR}.
- One combinational sub-module `ascii_hex_nib`: `rx_data` → `is_hex`, `nib[3:0]`.
- The FSM, accumulator, counter and output registers live in `uart_hex_cmd`.

## Test plan
- Send "1A2f",CR → `value=0x1A2F`, one `value_valid` pulse, 5 `echo_start` pulses with `echo_data` 0x31,0x41,0x32,0x66,0x0D, `err` never set.
- Send "12345",CR → `err` pulse on '5'; no `value_valid`; `value` keeps prior value; `digit_cnt` returns to 0 after CR.
- Send "ABC",BS,"D",CR → `value=0xABD`; `digit_cnt` sequence 1,2,3,2,3,0.
- Send "7G",CR → `err` on 'G', no commit; then "7",CR → `value=0x0007`.
- Send "12",ESC,CR → no commit, no `err`; `digit_cnt=0`. CR and LF alone in IDLE → echoes only.
- `rx_done` on two consecutive cycles ("3","4") then CR, with `reset` asserted mid-entry on a repeat → first run gives `value=0x0034`; after reset all outputs are 0 and the next "5",CR gives `0x0005`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: control-character codes and the hex command parser state type.
package uart_pkg;

  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_ESC = 8'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ERR   = 2'd2
  } hex_cmd_state_t;

endpackage

// File: rtl/ascii_hex_nib.sv
// Combinational ASCII hex digit decoder: flags 0-9/a-f/A-F and returns the nibble value.
module ascii_hex_nib (
  input  logic [7:0] rx_data,
  output logic       is_hex,
  output logic [3:0] nib
);

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // Low nibble of 'A'/'a' is 1, so adding 9 maps the letters onto 10..15.
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/uart_hex_cmd.sv
// Accumulates ASCII hex digits from the UART receiver, commits the value on CR,
// and echoes every received byte back to the transmitter.
module uart_hex_cmd
  import uart_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_done,
  input  logic [7:0]                 rx_data,
  output logic [4*NDIG-1:0]          value,
  output logic                       value_valid,
  output logic                       err,
  output logic [$clog2(NDIG+1)-1:0]  digit_cnt,
  output logic                       echo_start,
  output logic [7:0]                 echo_data
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  hex_cmd_state_t state, state_nxt;
  logic [W-1:0]   acc, acc_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           commit, err_set;
  logic           is_hex;
  logic [3:0]     nib;

  ascii_hex_nib u_nib (
    .rx_data (rx_data),
    .is_hex  (is_hex),
    .nib     (nib)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    err_set   = 1'b0;
    if (rx_done) begin
      if (is_hex) begin
        case (state)
          IDLE: begin
            acc_nxt   = W'(nib);
            cnt_nxt   = CW'(1);
            state_nxt = ACCUM;
          end
          ACCUM: begin
            if (cnt < CW'(NDIG)) begin
              acc_nxt = {acc[W-5:0], nib};
              cnt_nxt = cnt + CW'(1);
            end else begin
              err_set   = 1'b1;
              state_nxt = ERR;
            end
          end
          default: ;
        endcase
      end else begin
        case (rx_data)
          CHAR_CR: begin
            commit    = (state == ACCUM);
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
          CHAR_ESC: begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
          CHAR_BS: begin
            if (state == ACCUM) begin
              acc_nxt = acc >> 4;
              cnt_nxt = cnt - CW'(1);
              if (cnt == CW'(1)) state_nxt = IDLE;
            end
          end
          CHAR_LF: ;
          default: begin
            // Illegal byte: the digits so far stay frozen until CR or ESC.
            err_set = 1'b1;
            if (state == ACCUM) state_nxt = ERR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      echo_start  <= 1'b0;
      echo_data   <= 8'h00;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      value_valid <= commit;
      err         <= err_set;
      echo_start  <= rx_done;
      if (rx_done) echo_data <= rx_data;
      if (commit)  value     <= acc;
    end
  end

  assign digit_cnt = cnt;

endmodule

// File: tb/tb_uart_hex_cmd.sv
// Bench for uart_hex_cmd: directed command sequences plus random byte streams,
// compared every cycle against a digit-queue reference model.
module tb_uart_hex_cmd;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
  localparam int CW   = $clog2(NDIG + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_done = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [W-1:0]      value;
  logic              value_valid;
  logic              err;
  logic [CW-1:0]     digit_cnt;
  logic              echo_start;
  logic [7:0]        echo_data;

  uart_hex_cmd #(.NDIG(NDIG)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .digit_cnt   (digit_cnt),
    .echo_start  (echo_start),
    .echo_data   (echo_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the entry is a list of digit values plus a "corrupted" flag.
  int unsigned digits[$];
  bit          m_corrupt;
  int unsigned m_value;
  bit          m_vv, m_err, m_es;
  int unsigned m_ed;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 97 + 10;
    if (b >= "A" && b <= "F") return int'(b) - 65 + 10;
    return -1;
  endfunction

  function automatic int unsigned fold_digits();
    int unsigned v = 0;
    foreach (digits[i]) v = (v * 16 + digits[i]) % (1 << W);
    return v;
  endfunction

  task automatic model_reset();
    digits.delete();
    m_corrupt = 1'b0;
    m_value = 0; m_vv = 0; m_err = 0; m_es = 0; m_ed = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int h;
    h = hex_val(b);
    m_vv = 0; m_err = 0; m_es = 1; m_ed = b;
    if (h >= 0) begin
      if (!m_corrupt) begin
        if (digits.size() < NDIG) digits.push_back(h);
        else begin m_err = 1; m_corrupt = 1; end
      end
    end else if (b == 8'h0D) begin
      if (!m_corrupt && digits.size() > 0) begin
        m_value = fold_digits();
        m_vv = 1;
      end
      digits.delete(); m_corrupt = 0;
    end else if (b == 8'h1B) begin
      digits.delete(); m_corrupt = 0;
    end else if (b == 8'h08) begin
      if (!m_corrupt && digits.size() > 0) void'(digits.pop_back());
    end else if (b != 8'h0A) begin
      m_err = 1;
      if (digits.size() > 0) m_corrupt = 1;
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after the rising edge.
  task automatic step(input bit rst, input bit rx, input logic [7:0] b);
    @(negedge clk);
    reset = rst; rx_done = rx; rx_data = b;
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (rx) model_byte(b);
    else begin m_vv = 0; m_err = 0; m_es = 0; end
    check("value",       value,       m_value);
    check("value_valid", value_valid, m_vv);
    check("err",         err,         m_err);
    check("echo_start",  echo_start,  m_es);
    check("echo_data",   echo_data,   m_ed);
    check("digit_cnt",   digit_cnt,   digits.size());
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] pool[$];
    logic [7:0] b;
    model_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(2);

    send_str("1A2f"); send(8'h0D); idle(2);
    check("commit_1A2F", value, 16'h1A2F);
    send_str("12345"); send(8'h0D); idle(1);
    check("overflow_keeps_value", value, 16'h1A2F);
    send_str("ABC"); send(8'h08); send("D"); send(8'h0D); idle(1);
    check("backspace_value", value, 16'h0ABD);
    send_str("7G"); send(8'h0D); send("7"); send(8'h0D); idle(1);
    check("after_illegal", value, 16'h0007);
    send_str("12"); send(8'h1B); send(8'h0D); send(8'h0D); send(8'h0A); idle(1);
    send_str("ZZ"); send(8'h08); send("9"); send(8'h08); send(8'h08); idle(1);
    send("3"); send("4"); send(8'h0D);
    check("back_to_back", value, 16'h0034);
    send("3");
    step(1'b1, 1'b1, "4");
    idle(1);
    send("5"); send(8'h0D); idle(1);
    check("after_reset", value, 16'h0005);

    pool = '{"0","1","9","a","F","c","E",8'h0D,8'h0D,8'h1B,8'h08,8'h08,8'h0A,"G","x",8'h00,8'hFF};
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0) idle($urandom_range(1, 3));
      else if (r == 1) send(8'($urandom));
      else if (r == 2 && $urandom_range(0, 40) == 0) step(1'b1, $urandom_range(0, 1), 8'($urandom));
      else begin
        b = pool[$urandom_range(0, pool.size() - 1)];
        send(b);
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
